// File: rtl/button_conditioner_pkg.sv
// Shared constants for the push-button conditioning path: debounce lengths and button indices.
package button_conditioner_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
    localparam int unsigned SIM_DEBOUNCE_CYCLES     = 4;

    localparam int unsigned NUM_BTN = 3;
    localparam int unsigned BTN_C   = 0;
    localparam int unsigned BTN_L   = 1;
    localparam int unsigned BTN_R   = 2;

    // Counter only has to reach cycles-1, so $clog2(cycles) bits suffice for cycles >= 2.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/btn_debounce_pulse.sv
// One button channel: 2-flop synchronizer, debounce counter, debounced level and
// a registered single-cycle pulse on each accepted press.
module btn_debounce_pulse
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int unsigned          CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_q;
    logic             pulse_d;

    // A level change is accepted on the edge that completes DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                pulse_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the three raw push-buttons into single-cycle press pulses for the buttons FSM.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btnc,
    input  logic btnl,
    input  logic btnr,
    output logic btncZ,
    output logic btnlZ,
    output logic btnrZ
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_pulse;

    assign btn_raw[BTN_C] = btnc;
    assign btn_raw[BTN_L] = btnl;
    assign btn_raw[BTN_R] = btnr;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        btn_debounce_pulse #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw  (btn_raw[i]),
            .btn_pulse(btn_pulse[i])
        );
    end

    assign btncZ = btn_pulse[BTN_C];
    assign btnlZ = btn_pulse[BTN_L];
    assign btnrZ = btn_pulse[BTN_R];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner using a sample-history reference model.
module tb_button_conditioner;
    import button_conditioner_pkg::*;

    localparam int D    = int'(SIM_DEBOUNCE_CYCLES);
    localparam int NB   = int'(NUM_BTN);
    localparam int HMAX = 2048;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btnc  = 1'b0;
    logic btnl  = 1'b0;
    logic btnr  = 1'b0;
    logic btncZ, btnlZ, btnrZ;

    logic [NB-1:0] obs;
    assign obs = {btnrZ, btnlZ, btncZ};

    button_conditioner #(.DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .btnc (btnc),
        .btnl (btnl),
        .btnr (btnr),
        .btncZ(btncZ),
        .btnlZ(btnlZ),
        .btnrZ(btnrZ)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw samples per edge since reset; synchronized value seen at
    // edge e is the raw value sampled at edge e-2. The level flips once the last D
    // synchronized samples after the previous flip all disagree with it.
    bit            raw_h [NB][HMAX];
    int            pe;
    int            last_flip [NB];
    bit            stab [NB];
    logic [NB-1:0] exp_p;

    int sc_edge;
    int pulse_cnt   [NB];
    int pulse_first [NB];
    int pulse_last  [NB];

    function automatic bit sync_at(input int ch, input int e);
        return (e >= 3) ? raw_h[ch][e-2] : 1'b0;
    endfunction

    task automatic model_reset();
        pe    = 0;
        exp_p = '0;
        for (int ch = 0; ch < NB; ch++) begin
            last_flip[ch] = 0;
            stab[ch]      = 1'b0;
        end
    endtask

    task automatic model_edge(input logic [NB-1:0] in);
        bit ok;
        pe++;
        for (int ch = 0; ch < NB; ch++) begin
            raw_h[ch][pe] = in[ch];
            exp_p[ch]     = 1'b0;
            if (pe - last_flip[ch] >= D) begin
                ok = 1'b1;
                for (int k = pe - D + 1; k <= pe; k++)
                    if (sync_at(ch, k) == stab[ch]) ok = 1'b0;
                if (ok) begin
                    stab[ch]      = ~stab[ch];
                    last_flip[ch] = pe;
                    exp_p[ch]     = stab[ch];
                end
            end
        end
    endtask

    // Drive inputs at a negedge, clock one edge, return at the next negedge.
    task automatic step(input logic c, input logic l, input logic r);
        btnc = c;
        btnl = l;
        btnr = r;
        @(posedge clk);
        if (rst_n) model_edge({r, l, c});
        sc_edge++;
        @(negedge clk);
        for (int ch = 0; ch < NB; ch++) begin
            if (obs[ch] === 1'b1) begin
                if (pulse_cnt[ch] == 0) pulse_first[ch] = sc_edge;
                pulse_last[ch] = sc_edge;
                pulse_cnt[ch]++;
            end
        end
    endtask

    task automatic begin_scenario();
        btnc = 1'b0;
        btnl = 1'b0;
        btnr = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        sc_edge = 0;
        for (int ch = 0; ch < NB; ch++) begin
            pulse_cnt[ch]   = 0;
            pulse_first[ch] = -1;
            pulse_last[ch]  = -1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (obs !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_state: pulses=%b expected 000", obs);
        end
        // Reset must clear a live pulse without waiting for a clock edge.
        begin_scenario();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (obs !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_prepulse: pulses=%b expected 001", obs);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async_clear: pulses=%b expected 000", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_press();
        begin_scenario();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs !== exp_p) begin
                n_fail++;
                $display("FAIL clean_press edge %0d: pulses=%b expected %b", sc_edge, obs, exp_p);
            end
        end
        n_tests++;
        if (pulse_cnt[BTN_C] != 1 || pulse_first[BTN_C] != D + 2) begin
            n_fail++;
            $display("FAIL clean_press_latency: count=%0d edge=%0d expected count 1 edge %0d",
                     pulse_cnt[BTN_C], pulse_first[BTN_C], D + 2);
        end
        n_tests++;
        if (pulse_cnt[BTN_L] + pulse_cnt[BTN_R] != 0) begin
            n_fail++;
            $display("FAIL clean_press_isolation: l=%0d r=%0d expected 0 0",
                     pulse_cnt[BTN_L], pulse_cnt[BTN_R]);
        end
    endtask

    task automatic test_bounce();
        logic [8:0] pat;
        pat = 9'b1_0011_0011;
        begin_scenario();
        for (int i = 0; i < 24; i++) begin
            step(1'b0, (i < 9) ? pat[i] : 1'b1, 1'b0);
            n_tests++;
            if (obs !== exp_p) begin
                n_fail++;
                $display("FAIL bounce edge %0d: pulses=%b expected %b", sc_edge, obs, exp_p);
            end
        end
        n_tests++;
        if (pulse_cnt[BTN_L] != 1 || pulse_first[BTN_L] != 9 + D + 1) begin
            n_fail++;
            $display("FAIL bounce_single: count=%0d edge=%0d expected count 1 edge %0d",
                     pulse_cnt[BTN_L], pulse_first[BTN_L], 9 + D + 1);
        end
    endtask

    task automatic test_glitch();
        begin_scenario();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, (i < 3) ? 1'b1 : 1'b0);
            n_tests++;
            if (obs !== exp_p) begin
                n_fail++;
                $display("FAIL glitch edge %0d: pulses=%b expected %b", sc_edge, obs, exp_p);
            end
        end
        n_tests++;
        if (pulse_cnt[BTN_R] != 0) begin
            n_fail++;
            $display("FAIL glitch_nopulse: count=%0d expected 0", pulse_cnt[BTN_R]);
        end
    endtask

    task automatic test_release_repress();
        begin_scenario();
        for (int i = 0; i < 36; i++) begin
            step((i < 10 || (i >= 20 && i < 30)) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (obs !== exp_p) begin
                n_fail++;
                $display("FAIL repress edge %0d: pulses=%b expected %b", sc_edge, obs, exp_p);
            end
        end
        n_tests++;
        if (pulse_cnt[BTN_C] != 2 || pulse_first[BTN_C] != D + 2 || pulse_last[BTN_C] != 21 + D + 1) begin
            n_fail++;
            $display("FAIL repress_count: count=%0d first=%0d last=%0d expected 2 %0d %0d",
                     pulse_cnt[BTN_C], pulse_first[BTN_C], pulse_last[BTN_C], D + 2, 21 + D + 1);
        end
    endtask

    task automatic test_simultaneous();
        begin_scenario();
        for (int i = 0; i < 14; i++) begin
            step(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (obs !== exp_p) begin
                n_fail++;
                $display("FAIL simultaneous edge %0d: pulses=%b expected %b", sc_edge, obs, exp_p);
            end
        end
        n_tests++;
        if (pulse_first[BTN_L] != D + 2 || pulse_first[BTN_R] != D + 2 ||
            pulse_cnt[BTN_L] != 1 || pulse_cnt[BTN_R] != 1 || pulse_cnt[BTN_C] != 0) begin
            n_fail++;
            $display("FAIL simultaneous_align: l=%0d@%0d r=%0d@%0d c=%0d expected 1@%0d 1@%0d 0",
                     pulse_cnt[BTN_L], pulse_first[BTN_L], pulse_cnt[BTN_R], pulse_first[BTN_R],
                     pulse_cnt[BTN_C], D + 2, D + 2);
        end
    endtask

    task automatic test_reset_mid_count();
        begin_scenario();
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                rst_n = 1'b0;
                model_reset();
            end
            if (i == 5) rst_n = 1'b1;
            step(1'b1, 1'b0, 1'b0);
            n_tests++;
            if (obs !== exp_p) begin
                n_fail++;
                $display("FAIL reset_mid edge %0d: pulses=%b expected %b", sc_edge, obs, exp_p);
            end
        end
        n_tests++;
        if (pulse_cnt[BTN_C] != 1 || pulse_first[BTN_C] != 6 + D + 1) begin
            n_fail++;
            $display("FAIL reset_mid_latency: count=%0d edge=%0d expected count 1 edge %0d",
                     pulse_cnt[BTN_C], pulse_first[BTN_C], 6 + D + 1);
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] lvl;
        int            hold [NB];
        int            total;
        lvl = '0;
        for (int ch = 0; ch < NB; ch++) hold[ch] = 0;
        begin_scenario();
        for (int i = 0; i < 800; i++) begin
            for (int ch = 0; ch < NB; ch++) begin
                if (hold[ch] == 0) begin
                    lvl[ch]  = 1'($urandom_range(0, 1));
                    hold[ch] = int'($urandom_range(1, 2 * D + 3));
                end
                hold[ch]--;
            end
            step(lvl[BTN_C], lvl[BTN_L], lvl[BTN_R]);
            n_tests++;
            if (obs !== exp_p) begin
                n_fail++;
                $display("FAIL random edge %0d: pulses=%b expected %b", sc_edge, obs, exp_p);
            end
        end
        total = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2];
        n_tests++;
        if (total == 0) begin
            n_fail++;
            $display("FAIL random_activity: pulses=%0d expected nonzero", total);
        end
    endtask

    initial begin
        model_reset();
        sc_edge = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_release_repress();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000000 (10 ms at 100 MHz), consecutive stable cycles before a level change is accepted; legal range >= 2.
REQ-002 Port: clk  input  1  single system clock; all flops rise-edge triggered.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: btnc  input  1  raw centre push-button, asynchronous to clk, may bounce.
REQ-005 Port: btnl  input  1  raw left push-button, asynchronous, may bounce.
REQ-006 Port: btnr  input  1  raw right push-button, asynchronous, may bounce.
REQ-007 Port: btncZ  output  1  one-cycle press pulse for centre button; feeds buttons FSM.
REQ-008 Port: btnlZ  output  1  one-cycle press pulse for left button.
REQ-009 Port: btnrZ  output  1  one-cycle press pulse for right button.

Function
REQ-010 Each button SHALL be processed by an identical, fully independent channel; no cross-channel interaction.
REQ-011 Each channel SHALL pass its raw input through a 2-flop synchronizer (sync1, sync2); only sync2 feeds logic.
REQ-012 Each channel SHALL hold a debounced level `stable` and a counter `cnt` of width $clog2(DEBOUNCE_CYCLES).
REQ-013 Per edge: sync2 == stable -> cnt <= 0.
REQ-014 Per edge: sync2 != stable and cnt < DEBOUNCE_CYCLES-1 -> cnt <= cnt+1.
REQ-015 Per edge: sync2 != stable and cnt == DEBOUNCE_CYCLES-1 -> stable <= sync2, cnt <= 0.
REQ-016 Pulse output SHALL be registered: high for exactly one cycle following the edge where stable goes 0->1; low otherwise.
REQ-017 stable going 1->0 (release) SHALL produce no pulse.
REQ-018 Latency: raw first sampled high at edge 1 and held -> pulse high after edge DEBOUNCE_CYCLES+2, low after edge DEBOUNCE_CYCLES+3.
REQ-019 Any sync2 return to stable before acceptance SHALL clear cnt; glitches shorter than DEBOUNCE_CYCLES cycles produce no pulse and no level change.
REQ-020 A held button SHALL produce exactly one pulse regardless of hold duration; next pulse requires accepted release then accepted press.
REQ-021 Simultaneous presses on several buttons SHALL yield pulses on all affected outputs, same cycle if raw edges coincide.
REQ-022 cnt SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap).

Reset
REQ-023 rst_n low SHALL immediately clear sync1, sync2, stable, cnt, and all pulse outputs to 0, independent of clk.
REQ-024 Reset deassertion mid-debounce SHALL discard the partial count; a button held across reset release is treated as a fresh press and pulses after REQ-018 latency.
REQ-025 No pulse SHALL be emitted while rst_n is low.

Structure
REQ-026 Shared package SHALL hold DEBOUNCE_CYCLES default, simulation value SIM_DEBOUNCE_CYCLES = 4, and button index constants BTN_C=0, BTN_L=1, BTN_R=2.
REQ-027 One sub-module btn_debounce_pulse (one channel: synchronizer, counter, stable, pulse) SHALL be instantiated three times; top contains wiring only.
REQ-028 Outputs SHALL connect directly to btncZ/btnlZ/btnrZ inputs of the buttons FSM with no further gating.

Verification (DEBOUNCE_CYCLES = 4)
REQ-029 Clean press: btnc 0->1 sampled at edge 1, held 20 cycles -> btncZ high only between edges 6 and 7; btnlZ, btnrZ stay 0.
REQ-030 Bounce: btnl toggles 1,0,1,0 each 2 cycles then held 1 -> exactly one btnlZ pulse, 6 edges after final rising sample.
REQ-031 Glitch: btnr high for 3 cycles then 0 -> btnrZ never asserts; stable remains 0.
REQ-032 Release/re-press: btnc held 10 cycles, low 10, high 10 -> exactly two btncZ pulses, none on release.
REQ-033 Simultaneous: btnl and btnr rise same edge -> btnlZ and btnrZ pulse in same cycle.
REQ-034 Reset mid-count: btnc high, rst_n low at edge 4 for 2 cycles, btnc held -> no pulse during reset; one pulse 6 edges after first post-reset sample.
